ngs_boot_core_nios2_fast_cpu_mult_seq: RTL
==========================================

NGS_BOOT_CORE_NIOS2_FAST_CPU_MULT_SEQ -- requirements
Module: ngs_boot_core_nios2_fast_cpu_mult_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit operands and 16x16 partial products.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a request is offered.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 The block SHALL have port req_op, input, 2 bits: operation; 0 MUL, 1 MULXUU, 2 MULXSU, 3 MULXSS.
REQ-007 The block SHALL have ports req_src1 and req_src2, input, 32 bits each: operands A and B.
REQ-008 The block SHALL have port kill, input, 1 bit: synchronous abort of any operation in flight.
REQ-009 The block SHALL have ports cell_src1 and cell_src2, output, 32 bits each: operands driven to the multiplier cell.
REQ-010 The block SHALL have port cell_en, output, 1 bit: multiplier-cell register enable.
REQ-011 The block SHALL have ports cell_p1, cell_p2 and cell_p3, input, 32 bits each: registered cell partials lo*lo, src1lo*src2hi and src1hi*src2lo.
REQ-012 The block SHALL have port resp_valid, output, 1 bit: a result is available.
REQ-013 The block SHALL have port resp_ready, input, 1 bit: the consumer takes the result.
REQ-014 The block SHALL have port resp_result, output, 32 bits: the result word.
REQ-015 The block SHALL have port resp_err, output, 1 bit: the operation is unsupported in this build.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE1, CAPT1, ISSUE2, CAPT2 and DONE.
REQ-017 req_ready SHALL be 1 only in IDLE; on req_valid&&req_ready the block SHALL register A, B and op and go to ISSUE1.
REQ-018 In ISSUE1 the block SHALL drive cell_src1=A, cell_src2=B and cell_en=1, then go to CAPT1.
REQ-019 In all other states cell_en SHALL be 0, and cell_src1/cell_src2 SHALL hold their last driven values.
REQ-020 In CAPT1 the block SHALL form mid=p2+p3 (33 bits) and lo=p1+(mid[15:0]<<16) (33 bits), register lo[31:0], mid[32:16] and carry c=lo[32].
REQ-021 In CAPT1 the next state SHALL be DONE if op==MUL, otherwise ISSUE2.
REQ-022 In ISSUE2 the block SHALL drive cell_src1={16'h0,A[31:16]}, cell_src2={16'h0,B[31:16]} and cell_en=1.
REQ-023 In CAPT2 the block SHALL form hu = p1 + mid[32:16] + c (mod 2^32).
REQ-024 In CAPT2 the corrected high word SHALL be hu, minus B if A[31] and op is MULXSU or MULXSS, minus A if B[31] and op==MULXSS, all mod 2^32; the next state SHALL be DONE.
REQ-025 resp_result SHALL be the low word for MUL and the corrected high word otherwise.
REQ-026 In DONE resp_valid SHALL be 1, and resp_result and resp_err SHALL be stable until resp_ready.
REQ-027 On resp_valid&&resp_ready the block SHALL return to IDLE.
REQ-028 A new request SHALL NOT be accepted in the same cycle as the response handshake.
REQ-029 Latency from accept to resp_valid SHALL be 3 cycles for MUL and 5 cycles for MULX ops.
REQ-030 kill=1 in any state SHALL force IDLE next cycle with resp_valid=0; kill has priority over accept and the response handshake.
REQ-031 kill with req_valid in IDLE SHALL cause no accept.

Reset
REQ-032 Reset SHALL force state IDLE, with resp_valid=0, resp_err=0, resp_result=0, cell_en=0, cell_src1=0, cell_src2=0 and all captured registers 0.
REQ-033 Reset asserted mid-operation SHALL discard the operation, and no response SHALL follow.

Configuration
REQ-034 With NGS_BOOT_CORE_MULX_EN defined, all four ops SHALL be supported as above.
REQ-035 Without NGS_BOOT_CORE_MULX_EN, ISSUE2/CAPT2 logic SHALL be absent.
REQ-036 Without NGS_BOOT_CORE_MULX_EN, MULX ops SHALL go from IDLE straight to DONE (resp_valid 1 cycle after accept) with resp_result=0, resp_err=1 and no cell_en pulse; MUL is unchanged.

Structure
REQ-037 Package ngs_boot_core_mult_pkg SHALL hold the op encoding enum, the FSM state enum, and the constants MUL_LAT=3 and MULX_LAT=5.
REQ-038 The combinational partial-product adder and signed correction SHALL be the sub-module ngs_boot_core_nios2_fast_cpu_mult_comb; the FSM and registers stay in the top.

Verification
REQ-039 The bench SHALL drive MUL, 0xFFFFFFFF*0xFFFFFFFF, and check resp_result=0x00000001 with resp_valid at accept+3.
REQ-040 The bench SHALL drive MULXUU, 0xFFFFFFFF*0xFFFFFFFF, and check 0xFFFFFFFE at accept+5, plus exactly two cell_en pulses.
REQ-041 The bench SHALL drive MULXSU, 0xFFFFFFFF*0xFFFFFFFF, and check 0xFFFFFFFF; then MULXSS, same operands, and check 0x00000000.
REQ-042 The bench SHALL drive MULXSS, 0x80000000*0x80000000, and check 0x40000000; then MULXUU, 0x00010000*0x00010000, and check 0x00000001.
REQ-043 The bench SHALL hold resp_ready=0 for 4 cycles on MUL 3*5, and check resp_result=15 stable and req_ready=0 throughout.
REQ-044 The bench SHALL assert kill in CAPT1 of a MULXUU, check no response and IDLE next cycle, then check that a following MUL 7*6 returns 42.

Source files
------------

// File: rtl/ngs_boot_core_mult_pkg.sv
// Shared definitions for the sequential NIOS II multiply unit:
// the operation encoding, the FSM state encoding and the nominal latencies.
package ngs_boot_core_mult_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULXUU = 2'd1,
        OP_MULXSU = 2'd2,
        OP_MULXSS = 2'd3
    } mult_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE1 = 3'd1,
        ST_CAPT1  = 3'd2,
        ST_ISSUE2 = 3'd3,
        ST_CAPT2  = 3'd4,
        ST_DONE   = 3'd5
    } mult_state_t;

    // Cycles from the accept cycle to the first cycle with resp_valid high.
    localparam int MUL_LAT  = 3;
    localparam int MULX_LAT = 5;

endpackage

// File: rtl/ngs_boot_core_nios2_fast_cpu_mult_comb.sv
// Combinational partial-product adder and signed high-word correction.
// The first pass folds the three 16x16 partials into the low word; the
// second pass (present only with NGS_BOOT_CORE_MULX_EN defined) adds the
// hi*hi partial to the carried-over middle sum and applies signed fix-ups.
module ngs_boot_core_nios2_fast_cpu_mult_comb
    import ngs_boot_core_mult_pkg::*;
(
    input  logic [31:0] p1,
    input  logic [31:0] p2,
    input  logic [31:0] p3,
`ifdef NGS_BOOT_CORE_MULX_EN
    input  logic [16:0] mid_hi_q,
    input  logic        c_q,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  mult_op_t    op,
    output logic [16:0] mid_hi,
    output logic        carry,
    output logic [31:0] hi_word,
`endif
    output logic [31:0] lo_word
);

    logic [32:0] mid;
    logic [32:0] lo;

    // First pass: cross partials summed, low half shifted into the low word.
    always_comb begin
        mid = {1'b0, p2} + {1'b0, p3};
        lo  = {1'b0, p1} + {1'b0, mid[15:0], 16'h0000};
    end

    assign lo_word = lo[31:0];

`ifdef NGS_BOOT_CORE_MULX_EN
    logic [31:0] hu;

    assign mid_hi = mid[32:16];
    assign carry  = lo[32];

    // Second pass: unsigned high word, then subtract the other operand for
    // each operand that is treated as signed and negative.
    always_comb begin
        hu      = p1 + {15'h0000, mid_hi_q} + {31'h0, c_q};
        hi_word = hu;
        if (a[31] && (op == OP_MULXSU || op == OP_MULXSS)) begin
            hi_word = hi_word - b;
        end
        if (b[31] && (op == OP_MULXSS)) begin
            hi_word = hi_word - a;
        end
    end
`else
    // Only the low word is needed when the extended ops are not built.
    logic unused_upper;
    assign unused_upper = ^{mid[32:16], lo[32]};
`endif

endmodule

// File: rtl/ngs_boot_core_nios2_fast_cpu_mult_seq.sv
// Sequential multiply controller for the NIOS II fast core. It drives an
// external registered 16x16 multiplier cell once for MUL (low word) and a
// second time for the MULX family (high word).
// Build option: NGS_BOOT_CORE_MULX_EN enables MULXUU/MULXSU/MULXSS; without
// it those ops complete at once with resp_err=1 and resp_result=0.
module ngs_boot_core_nios2_fast_cpu_mult_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        kill,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_err
);
    import ngs_boot_core_mult_pkg::*;

    mult_state_t state_q, state_d;
    logic [31:0] cell_src1_q, cell_src1_d;
    logic [31:0] cell_src2_q, cell_src2_d;
    logic [31:0] result_q, result_d;
    logic        err_q, err_d;
    logic [31:0] lo_word;
    logic        req_is_mul;

`ifdef NGS_BOOT_CORE_MULX_EN
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    mult_op_t    op_q, op_d;
    logic [16:0] mid_hi_q, mid_hi_d, mid_hi;
    logic        c_q, c_d, carry;
    logic [31:0] hi_word;
`endif

    assign req_is_mul = (mult_op_t'(req_op) == OP_MUL);

    ngs_boot_core_nios2_fast_cpu_mult_comb u_comb (
        .p1       (cell_p1),
        .p2       (cell_p2),
        .p3       (cell_p3),
`ifdef NGS_BOOT_CORE_MULX_EN
        .mid_hi_q (mid_hi_q),
        .c_q      (c_q),
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
        .mid_hi   (mid_hi),
        .carry    (carry),
        .hi_word  (hi_word),
`endif
        .lo_word  (lo_word)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state; kill overrides accept and the response handshake.
    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
`ifdef NGS_BOOT_CORE_MULX_EN
                        state_d = ST_ISSUE1;
`else
                        state_d = req_is_mul ? ST_ISSUE1 : ST_DONE;
`endif
                    end
                end
                ST_ISSUE1: state_d = ST_CAPT1;
`ifdef NGS_BOOT_CORE_MULX_EN
                ST_CAPT1:  state_d = (op_q == OP_MUL) ? ST_DONE : ST_ISSUE2;
                ST_ISSUE2: state_d = ST_CAPT2;
                ST_CAPT2:  state_d = ST_DONE;
`else
                ST_CAPT1:  state_d = ST_DONE;
`endif
                ST_DONE:   if (resp_ready) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake and cell-enable outputs decoded from the current state.
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_DONE);
`ifdef NGS_BOOT_CORE_MULX_EN
        cell_en    = (state_q == ST_ISSUE1) || (state_q == ST_ISSUE2);
`else
        cell_en    = (state_q == ST_ISSUE1);
`endif
    end

    // Datapath next values: operands are loaded into the cell registers on
    // the transition into an ISSUE state so they are present during it.
    // The low word goes straight into the result register in CAPT1; for the
    // MULX ops it is overwritten by the corrected high word in CAPT2.
    always_comb begin
        cell_src1_d = cell_src1_q;
        cell_src2_d = cell_src2_q;
        result_d    = result_q;
        err_d       = err_q;
`ifdef NGS_BOOT_CORE_MULX_EN
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        mid_hi_d    = mid_hi_q;
        c_d         = c_q;
`endif
        if (!kill) begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
`ifdef NGS_BOOT_CORE_MULX_EN
                        a_d         = req_src1;
                        b_d         = req_src2;
                        op_d        = mult_op_t'(req_op);
                        cell_src1_d = req_src1;
                        cell_src2_d = req_src2;
                        err_d       = 1'b0;
`else
                        if (req_is_mul) begin
                            cell_src1_d = req_src1;
                            cell_src2_d = req_src2;
                            err_d       = 1'b0;
                        end else begin
                            result_d    = 32'h0;
                            err_d       = 1'b1;
                        end
`endif
                    end
                end
                ST_CAPT1: begin
                    result_d = lo_word;
`ifdef NGS_BOOT_CORE_MULX_EN
                    mid_hi_d = mid_hi;
                    c_d      = carry;
                    if (op_q != OP_MUL) begin
                        cell_src1_d = {16'h0000, a_q[31:16]};
                        cell_src2_d = {16'h0000, b_q[31:16]};
                    end
`endif
                end
`ifdef NGS_BOOT_CORE_MULX_EN
                ST_CAPT2: result_d = hi_word;
`endif
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cell_src1_q <= 32'h0;
            cell_src2_q <= 32'h0;
            result_q    <= 32'h0;
            err_q       <= 1'b0;
`ifdef NGS_BOOT_CORE_MULX_EN
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            op_q        <= OP_MUL;
            mid_hi_q    <= 17'h0;
            c_q         <= 1'b0;
`endif
        end else begin
            cell_src1_q <= cell_src1_d;
            cell_src2_q <= cell_src2_d;
            result_q    <= result_d;
            err_q       <= err_d;
`ifdef NGS_BOOT_CORE_MULX_EN
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            mid_hi_q    <= mid_hi_d;
            c_q         <= c_d;
`endif
        end
    end

    assign cell_src1   = cell_src1_q;
    assign cell_src2   = cell_src2_q;
    assign resp_result = result_q;
    assign resp_err    = err_q;

endmodule
